// File: rtl/synth_pkg.sv
// Shared types and constants for the synthesiser playback block:
// key count, record word width, FSM state encoding, end-marker code,
// per-note half-period table and the note-code decode helpers.
package synth_pkg;

    localparam int NUM_KEYS = 11;
    localparam int REC_W    = 129;

    localparam logic [3:0] END_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Half period of the square wave in clock cycles, indexed by note code.
    // Codes 1..11 follow 24-2c; rests and the end marker carry 0.
    localparam logic [4:0] HALF_PERIOD [16] = '{
        5'd0,  5'd22, 5'd20, 5'd18, 5'd16, 5'd14, 5'd12, 5'd10,
        5'd8,  5'd6,  5'd4,  5'd2,  5'd0,  5'd0,  5'd0,  5'd0
    };

    function automatic logic is_note(input logic [3:0] code);
        return (code >= 4'd1) && (code <= 4'd11);
    endfunction

    function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [3:0] code);
        if (is_note(code))
            return NUM_KEYS'(1) << (code - 4'd1);
        else
            return '0;
    endfunction

endpackage

// File: rtl/synth_tone_gen.sv
// Square-wave tone generator. Toggles sound every HALF_PERIOD[code]
// cycles while code is a playable note; a restart strobe forces the
// wave back to 0 so every slot starts from a known phase.
module synth_tone_gen
    import synth_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] code,
    input  logic       restart,
    output logic       sound
);

    logic [4:0] cnt;

    // Half-period counter and output toggle; rests hold the wave low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            sound <= 1'b0;
        end else if (restart || !is_note(code)) begin
            cnt   <= '0;
            sound <= 1'b0;
        end else if (cnt == HALF_PERIOD[code] - 5'd1) begin
            cnt   <= '0;
            sound <= ~sound;
        end else begin
            cnt   <= cnt + 5'd1;
        end
    end

endmodule

// File: rtl/synth_playback.sv
// Replays a captured recorder word slot by slot: each 4-bit slot code is
// held for NOTE_TICKS cycles as a one-hot key plus a square-wave tone.
// Optional build macro SYNTH_PLAYBACK_LOOP_EN: on completion, wrap back
// to slot 0 instead of pulsing done, until stop or rst.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// PLAY  | replaying shadow slots; busy high
// DONE  | one-cycle done pulse, then back to IDLE
module synth_playback
    import synth_pkg::*;
#(
    parameter int NOTE_TICKS = 500,
    parameter int SLOTS      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [REC_W-1:0]    record,
    output logic [NUM_KEYS-1:0] keys_out,
    output logic                sound,
    output logic                busy,
    output logic                done,
    output logic [4:0]          slot_idx
);

    localparam int             TW        = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(NOTE_TICKS - 1);
    localparam logic [4:0]     SLOT_LAST = 5'(SLOTS - 1);

    state_t           state, state_nxt;
    logic [REC_W-2:0] shadow;
    logic [4:0]       slot, slot_inc;
    logic [TW-1:0]    tick;
    logic [3:0]       cur_code, nxt_code;
    logic             tick_wrap, at_end, capture, restart, tone;

    assign slot_inc  = slot + 5'd1;
    assign cur_code  = shadow[{slot, 2'b00} +: 4];
    assign nxt_code  = shadow[{slot_inc, 2'b00} +: 4];
    assign tick_wrap = (tick == TICK_LAST);
    // Look ahead one slot so an end marker finishes the pass on the very
    // edge that would have entered it.
    assign at_end    = (slot == SLOT_LAST) || (nxt_code == END_CODE);
    assign capture   = (state == IDLE) && start && record[REC_W-1];
    assign restart   = capture || ((state == PLAY) && tick_wrap);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; stop takes priority over slot advance.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (record[REC_W-1] && (record[3:0] != END_CODE))
                        state_nxt = PLAY;
                    else
                        state_nxt = DONE;
                end
            end
            PLAY: begin
                if (stop)
                    state_nxt = IDLE;
                else if (tick_wrap && at_end) begin
`ifdef SYNTH_PLAYBACK_LOOP_EN
                    state_nxt = PLAY;
`else
                    state_nxt = DONE;
`endif
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow capture plus slot/tick sequencing; both idle at 0 outside PLAY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
            slot   <= '0;
            tick   <= '0;
        end else if (capture) begin
            shadow <= record[REC_W-2:0];
            slot   <= '0;
            tick   <= '0;
        end else if ((state == PLAY) && !stop) begin
            if (tick_wrap) begin
                tick <= '0;
                slot <= at_end ? 5'd0 : slot_inc;
            end else begin
                tick <= tick + TW'(1);
            end
        end else begin
            slot <= '0;
            tick <= '0;
        end
    end

    synth_tone_gen u_tone (
        .clk     (clk),
        .rst     (rst),
        .code    ((state == PLAY) ? cur_code : 4'h0),
        .restart (restart),
        .sound   (tone)
    );

    // Outputs decoded from registered state so reset silences them at once.
    always_comb begin
        busy     = (state == PLAY);
        done     = (state == DONE);
        keys_out = busy ? key_onehot(cur_code) : '0;
        slot_idx = busy ? slot : 5'd0;
        sound    = busy & tone;
    end

endmodule

// File: tb/tb_synth_playback.sv
// Directed bench for synth_playback with NOTE_TICKS=4. Expected key,
// tone and handshake values are hand-derived per slot. Builds with or
// without SYNTH_PLAYBACK_LOOP_EN.
module tb_synth_playback;
    import synth_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                stop;
    logic [REC_W-1:0]    record;
    logic [NUM_KEYS-1:0] keys_out;
    logic                sound;
    logic                busy;
    logic                done;
    logic [4:0]          slot_idx;

    int n_checks = 0;
    int n_errors = 0;

    synth_playback #(.NOTE_TICKS(4), .SLOTS(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .record   (record),
        .keys_out (keys_out),
        .sound    (sound),
        .busy     (busy),
        .done     (done),
        .slot_idx (slot_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [REC_W-1:0] mk(input logic v, input logic [3:0] a,
                                             input logic [3:0] b, input logic [3:0] c,
                                             input logic [3:0] d, input logic [3:0] e);
        logic [REC_W-1:0] r;
        r          = '0;
        r[128]     = v;
        r[3:0]     = a;
        r[7:4]     = b;
        r[11:8]    = c;
        r[15:12]   = d;
        r[19:16]   = e;
        return r;
    endfunction

    // One full slot: four cycles of fixed keys/slot, sound pattern bit i per cycle.
    task automatic note(input logic [10:0] k, input logic [4:0] s, input logic [3:0] snd);
        for (int i = 0; i < 4; i++) begin
            chk("keys",  32'(keys_out), 32'(k));
            chk("slot",  32'(slot_idx), 32'(s));
            chk("busy",  32'(busy),     32'd1);
            chk("sound", 32'(sound),    32'(snd[i]));
            step();
        end
    endtask

    task automatic kick(input logic [REC_W-1:0] r);
        record = r;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    // End of a pass: single-shot expects a done pulse, loop build expects wrap to slot 0.
    task automatic finish_pass();
`ifdef SYNTH_PLAYBACK_LOOP_EN
        chk("loop_busy", 32'(busy),     32'd1);
        chk("loop_slot", 32'(slot_idx), 32'd0);
        chk("loop_done", 32'(done),     32'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("loop_stop_busy", 32'(busy), 32'd0);
        chk("loop_stop_done", 32'(done), 32'd0);
`else
        chk("done_pulse", 32'(done),     32'd1);
        chk("done_busy",  32'(busy),     32'd0);
        chk("done_keys",  32'(keys_out), 32'd0);
        chk("done_sound", 32'(sound),    32'd0);
        chk("done_slot",  32'(slot_idx), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("done_once",      32'(done), 32'd0);
        chk("start_in_done",  32'(busy), 32'd0);
`endif
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        record = '0;
        #3;
        chk("rst_keys",  32'(keys_out), 32'd0);
        chk("rst_busy",  32'(busy),     32'd0);
        chk("rst_done",  32'(done),     32'd0);
        chk("rst_sound", 32'(sound),    32'd0);
        chk("rst_slot",  32'(slot_idx), 32'd0);
        step();
        rst = 1'b0;

        // Basic pass 1,2,end; record changes and a stray start mid-play are ignored.
        kick(mk(1'b1, 4'd1, 4'd2, 4'hF, 4'd0, 4'd0));
        record = mk(1'b1, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5);
        note(11'h001, 5'd0, 4'b0000);
        start = 1'b1;
        note(11'h002, 5'd1, 4'b0000);
        start = 1'b0;
        finish_pass();

        // Invalid record: straight to done, never busy.
        kick(mk(1'b0, 4'd1, 4'd2, 4'hF, 4'd0, 4'd0));
        chk("inv_done", 32'(done),     32'd1);
        chk("inv_busy", 32'(busy),     32'd0);
        chk("inv_keys", 32'(keys_out), 32'd0);
        step();
        chk("inv_done2", 32'(done), 32'd0);
        chk("inv_busy2", 32'(busy), 32'd0);

        // Highest note toggles every 2 cycles; rests 0 and 12; code 6 -> key bit 5.
        kick(mk(1'b1, 4'd11, 4'd0, 4'd12, 4'd6, 4'hF));
        note(11'h400, 5'd0, 4'b1100);
        note(11'h000, 5'd1, 4'b0000);
        note(11'h000, 5'd2, 4'b0000);
        note(11'h020, 5'd3, 4'b0000);
        finish_pass();

        // Stop during slot 1: quiet at once, no done, replay restarts at slot 0.
        kick(mk(1'b1, 4'd1, 4'd2, 4'hF, 4'd0, 4'd0));
        note(11'h001, 5'd0, 4'b0000);
        chk("pre_stop_keys", 32'(keys_out), 32'h002);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_keys",  32'(keys_out), 32'd0);
        chk("stop_busy",  32'(busy),     32'd0);
        chk("stop_done",  32'(done),     32'd0);
        chk("stop_sound", 32'(sound),    32'd0);
        step();
        chk("stop_nodone", 32'(done), 32'd0);
        kick(mk(1'b1, 4'd1, 4'd2, 4'hF, 4'd0, 4'd0));
        note(11'h001, 5'd0, 4'b0000);
        note(11'h002, 5'd1, 4'b0000);
        finish_pass();

        // Async reset mid-play (slot 1), then an immediate start is honoured.
        kick(mk(1'b1, 4'd3, 4'd4, 4'hF, 4'd0, 4'd0));
        note(11'h004, 5'd0, 4'b0000);
        step();
        rst = 1'b1;
        #1;
        chk("arst_keys", 32'(keys_out), 32'd0);
        chk("arst_busy", 32'(busy),     32'd0);
        chk("arst_slot", 32'(slot_idx), 32'd0);
        chk("arst_done", 32'(done),     32'd0);
        #1;
        rst = 1'b0;
        kick(mk(1'b1, 4'd2, 4'hF, 4'd0, 4'd0, 4'd0));
        note(11'h002, 5'd0, 4'b0000);
        finish_pass();

        // All 32 slots play code 1; completion after the last slot.
        kick({1'b1, {32{4'h1}}});
        for (int s = 0; s < 32; s++)
            note(11'h001, 5'(s), 4'b0000);
        finish_pass();

`ifdef SYNTH_PLAYBACK_LOOP_EN
        // Loop build: single note followed by end marker repeats until stop.
        kick(mk(1'b1, 4'd1, 4'hF, 4'd0, 4'd0, 4'd0));
        for (int r = 0; r < 3; r++) begin
            note(11'h001, 5'd0, 4'b0000);
            chk("loop_rep_done", 32'(done), 32'd0);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("loop_end_busy", 32'(busy), 32'd0);
        chk("loop_end_done", 32'(done), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
